gray_conv_pipe: RTL and testbench
=================================

// Module: gray_conv_pipe
// PURPOSE
//   Parametrised, pipelined code converter, successor to the 4-bit combinational BCD->Gray gate block.
//   Per-beat mode selects one of four operations:
//     - binary->Gray
//     - Gray->binary
//     - per-digit BCD->Gray with invalid-digit flag
//     - internal Gray counter
//   Two register stages with valid/ready handshake on both sides.
//   Sits between lab datapath producers (encoders, counters) and consumers (display, position decode).
// PARAMETERS
//   WIDTH  8  data width in bits; must be a multiple of 4 (BCD mode works per 4-bit digit); min 4
// PORTS
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      input beat valid
//   in_ready   out  1      block can accept a beat this cycle
//   in_mode    in   2      0=BIN2GRAY 1=GRAY2BIN 2=BCD2GRAY 3=COUNT
//   in_data    in   WIDTH  operand (ignored in COUNT)
//   cnt_clr    in   1      synchronous clear of internal counter
//   out_valid  out  1      output beat valid
//   out_ready  in   1      consumer accepts output beat
//   out_data   out  WIDTH  converted result
//   out_mode   out  2      mode the beat was issued with
//   out_err    out  1      BCD digit >9 seen (BCD2GRAY only, else 0)
// BEHAVIOUR
//   Reset (async, immediate):
//     - s1_valid = s2_valid = 0
//     - out_valid = 0; out_data, out_mode, out_err = 0
//     - counter = 0; in_ready = 1 on the first cycle after reset release
//     - Reset mid-operation drops all in-flight beats; nothing is replayed.
//   Handshake:
//     - Transfer when valid && ready on a side.
//     - out_valid/out_data/out_mode/out_err hold stable while out_valid && !out_ready.
//     - adv2 = !s2_valid || out_ready; adv1 = !s1_valid || adv2; in_ready = adv1 (combinational from out_ready, no skid).
//     - Stage 1 captures the computed result on in_valid && in_ready.
//     - Stage 2 (output regs) captures s1 when s1_valid && adv2.
//     - s1_valid / s2_valid clear when their contents move on and nothing replaces them.
//   Latency and throughput:
//     - Latency 2 cycles: a beat accepted at edge N is visible on out_* after edge N+1.
//     - 1 beat/cycle sustained with out_ready=1.
//   Arithmetic (all computed combinationally before stage 1):
//     - BIN2GRAY: g = d ^ (d >> 1).
//     - GRAY2BIN: b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] ^ g[i].
//     - BCD2GRAY: each nibble k converted independently (nibble ^ nibble>>1).
//       A nibble >9 yields 4'b0000 for that digit and sets err; other digits still convert.
//     - COUNT: result = cnt ^ (cnt >> 1).
//       cnt increments by 1 on each accepted COUNT beat, modulo 2^WIDTH (wraps 2^WIDTH-1 -> 0).
//   Counter control:
//     - cnt_clr=1 sets cnt=0 at the next edge, with priority over increment.
//     - If cnt_clr and an accepted COUNT beat coincide, that beat uses the pre-clear cnt value; cnt becomes 0.
//   Mode mixing:
//     - Mode is per beat; beats of different modes may be interleaved back-to-back.
//     - Non-COUNT beats leave cnt unchanged.
// TESTING
//   WIDTH=8, out_ready=1:
//     - BIN2GRAY 0x2D -> out_data 0x3B, out_err 0, exactly 2 cycles after accept.
//     - GRAY2BIN 0x3B -> 0x2D; GRAY2BIN 0x80 -> 0xFF.
//   BCD2GRAY:
//     - 0x59 -> out_data 0x7D, err 0.
//     - 0x5A -> out_data 0x70, err 1.
//     - 0x00 -> 0x00, err 0.
//   COUNT:
//     - After reset, 4 beats -> 0x00, 0x01, 0x03, 0x02.
//     - Preload by 255 beats, beat 255 -> 0x80, next beat -> 0x00 (wrap).
//     - cnt_clr with a COUNT beat -> that beat uses the old value, the next beat gives 0x00.
//   Backpressure:
//     - Stream 5 mixed-mode beats, hold out_ready=0 for 3 cycles.
//     - in_ready drops once both stages are full; out_* stable while stalled.
//     - All 5 results arrive in order, none lost or duplicated.
//   Reset mid-stream:
//     - Assert rst asynchronously between edges with both stages full.
//     - out_valid -> 0 immediately and counter -> 0; the next COUNT beat outputs 0x00.

Source files
------------

// File: rtl/gray_conv_pipe_if.sv
// Bundle of the input/output beat channels of gray_conv_pipe.
//
// Handshake: a beat moves across a side on a rising clock edge where that
// side's valid and ready are both high. A producer holds valid and its
// payload until the transfer happens. The consumer's ready may depend
// combinationally on the downstream ready. in_ready is such a signal:
// it is derived from out_ready in the same cycle.
interface gray_conv_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [1:0]       in_mode;
  logic [WIDTH-1:0] in_data;
  logic             cnt_clr;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_mode;
  logic             out_err;

  // Producer/consumer side (testbench or surrounding datapath)
  modport master (
    output in_valid, in_mode, in_data, cnt_clr, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_err
  );

  // Converter side
  modport slave (
    input  in_valid, in_mode, in_data, cnt_clr, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_err
  );
endinterface

// File: rtl/gray_conv_pipe.sv
// Two-stage pipelined code converter: binary->Gray, Gray->binary,
// per-digit BCD->Gray with an invalid-digit flag, and an internal Gray
// counter. The result is computed combinationally before stage 1. Stage 2
// holds the output registers. Ready propagates backwards combinationally,
// so there is no skid buffer.
module gray_conv_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  gray_conv_pipe_if.slave  bus
);

  localparam logic [1:0] MODE_B2G   = 2'd0;
  localparam logic [1:0] MODE_G2B   = 2'd1;
  localparam logic [1:0] MODE_BCD   = 2'd2;
  localparam logic [1:0] MODE_COUNT = 2'd3;
  localparam int         NDIG       = WIDTH / 4;

  if ((WIDTH % 4) != 0 || WIDTH < 4) begin : g_width_check
    $error("gray_conv_pipe: WIDTH must be a multiple of 4 and at least 4");
  end

  logic             s1_valid_q;
  logic [WIDTH-1:0] s1_data_q;
  logic [1:0]       s1_mode_q;
  logic             s1_err_q;
  logic             s2_valid_q;
  logic [WIDTH-1:0] s2_data_q;
  logic [1:0]       s2_mode_q;
  logic             s2_err_q;
  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;
  logic [WIDTH-1:0] res_d;
  logic             err_d;
  logic [3:0]       nib;
  logic             adv1;
  logic             adv2;
  logic             accept;

  // Backpressure chain: a stage may load when empty or when its contents
  // leave at the same edge.
  always_comb begin
    adv2   = !s2_valid_q || bus.out_ready;
    adv1   = !s1_valid_q || adv2;
    accept = bus.in_valid && adv1;
  end

  assign bus.in_ready  = adv1;
  assign bus.out_valid = s2_valid_q;
  assign bus.out_data  = s2_data_q;
  assign bus.out_mode  = s2_mode_q;
  assign bus.out_err   = s2_err_q;

  // Per-mode conversion of the incoming operand (or of the counter)
  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    nib   = '0;
    case (bus.in_mode)
      MODE_B2G: res_d = bus.in_data ^ (bus.in_data >> 1);
      MODE_G2B: begin
        // Binary bit i is the XOR of all Gray bits from i upwards.
        for (int i = 0; i < WIDTH; i++) begin
          res_d[i] = ^(bus.in_data >> i);
        end
      end
      MODE_BCD: begin
        // Digits are independent; an invalid digit zeroes only itself.
        for (int k = 0; k < NDIG; k++) begin
          nib = bus.in_data[4*k +: 4];
          if (nib > 4'd9) begin
            res_d[4*k +: 4] = 4'b0000;
            err_d           = 1'b1;
          end else begin
            res_d[4*k +: 4] = nib ^ (nib >> 1);
          end
        end
      end
      default: res_d = cnt_q ^ (cnt_q >> 1);
    endcase
  end

  // Counter next state: clear wins over an accepted COUNT beat, which
  // still reports the pre-clear value.
  always_comb begin
    cnt_d = cnt_q;
    if (bus.cnt_clr) begin
      cnt_d = '0;
    end else if (accept && bus.in_mode == MODE_COUNT) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Stage 1: capture a fresh result, or empty out when contents move on
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_mode_q  <= '0;
      s1_err_q   <= 1'b0;
    end else if (accept) begin
      s1_valid_q <= 1'b1;
      s1_data_q  <= res_d;
      s1_mode_q  <= bus.in_mode;
      s1_err_q   <= err_d;
    end else if (adv2) begin
      s1_valid_q <= 1'b0;
    end
  end

  // Stage 2 (output registers): take stage 1 whenever the output may advance
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_mode_q  <= '0;
      s2_err_q   <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_data_q <= s1_data_q;
        s2_mode_q <= s1_mode_q;
        s2_err_q  <= s1_err_q;
      end
    end
  end

endmodule

// File: tb/tb_gray_conv_pipe.sv
// Self-checking bench for gray_conv_pipe at WIDTH=8.
module tb_gray_conv_pipe;

  localparam int W = 8;

  typedef struct {
    logic [1:0]   mode;
    logic [W-1:0] data;
    logic [W-1:0] exp_data;
    logic         exp_err;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  gray_conv_pipe_if #(.WIDTH(W)) bus ();

  gray_conv_pipe #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // ---------------- scoreboard ----------------
  logic [W+2:0] exp_q[$];
  logic [W+2:0] mon_exp;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare each output beat as it transfers (out_ready is stable at negedge)
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_beat got=%h at %0t",
                 {bus.out_mode, bus.out_err, bus.out_data}, $time);
      end else begin
        mon_exp = exp_q.pop_front();
        check("out_beat", 32'({bus.out_mode, bus.out_err, bus.out_data}), 32'(mon_exp));
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; returns just after the accepting edge.
  task automatic send(input logic [1:0] m, input logic [W-1:0] d, input logic clr,
                      input logic [W-1:0] ed, input logic ee);
    int waited = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    bus.cnt_clr  = clr;
    @(negedge clk);
    while (!bus.in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL send_timeout got=in_ready0 exp=in_ready1 at %0t", $time);
    end else begin
      exp_q.push_back({m, ee, ed});
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.cnt_clr  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [W-1:0] gray_of(input logic [W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [W-1:0] bin_of(input logic [W-1:0] g);
    logic [W-1:0] b;
    logic acc;
    acc = 1'b0;
    for (int i = W - 1; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  // ---------------- test sequence ----------------
  vec_t tbl[11];
  logic [W+2:0] held;
  logic [W-1:0] rd;
  logic [1:0]   rm;

  initial begin
    tbl[0]  = '{2'd0, 8'h2D, 8'h3B, 1'b0};
    tbl[1]  = '{2'd0, 8'hFF, 8'h80, 1'b0};
    tbl[2]  = '{2'd0, 8'h00, 8'h00, 1'b0};
    tbl[3]  = '{2'd1, 8'h3B, 8'h2D, 1'b0};
    tbl[4]  = '{2'd1, 8'h80, 8'hFF, 1'b0};
    tbl[5]  = '{2'd1, 8'h01, 8'h01, 1'b0};
    tbl[6]  = '{2'd2, 8'h59, 8'h7D, 1'b0};
    tbl[7]  = '{2'd2, 8'h5A, 8'h70, 1'b1};
    tbl[8]  = '{2'd2, 8'h00, 8'h00, 1'b0};
    tbl[9]  = '{2'd2, 8'hF3, 8'h02, 1'b1};
    tbl[10] = '{2'd2, 8'h99, 8'hDD, 1'b0};

    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_mode   = 2'd0;
    bus.in_data   = '0;
    bus.cnt_clr   = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data",  32'(bus.out_data),  32'd0);
    check("rst_out_mode",  32'(bus.out_mode),  32'd0);
    check("rst_out_err",   32'(bus.out_err),   32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Latency: accept at edge N, visible after edge N+1
    @(posedge clk);
    #1;
    bus.in_valid = 1'b1;
    bus.in_mode  = 2'd0;
    bus.in_data  = 8'h2D;
    @(negedge clk);
    check("lat_in_ready", 32'(bus.in_ready), 32'd1);
    exp_q.push_back({2'd0, 1'b0, 8'h3B});
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("lat_after_n", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("lat_after_n1", 32'({bus.out_valid, bus.out_data}), 32'({1'b1, 8'h3B}));
    @(posedge clk);
    #1;

    // Table-driven conversions, back to back
    for (int i = 0; i < 11; i++) begin
      send(tbl[i].mode, tbl[i].data, 1'b0, tbl[i].exp_data, tbl[i].exp_err);
    end
    drain();

    // COUNT after reset: 0,1,3,2
    send(2'd3, 8'hAA, 1'b0, 8'h00, 1'b0);
    send(2'd3, 8'h55, 1'b0, 8'h01, 1'b0);
    send(2'd0, 8'h02, 1'b0, 8'h03, 1'b0);  // non-COUNT beat leaves cnt alone
    send(2'd3, 8'h00, 1'b0, 8'h03, 1'b0);
    send(2'd3, 8'h00, 1'b0, 8'h02, 1'b0);
    drain();

    // Standalone clear, then preload 255 beats and wrap
    bus.cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    bus.cnt_clr = 1'b0;
    for (int i = 0; i < 255; i++) begin
      send(2'd3, 8'h00, 1'b0, gray_of(W'(i)), 1'b0);
    end
    send(2'd3, 8'h00, 1'b0, 8'h80, 1'b0);
    send(2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
    // Clear coinciding with a COUNT beat: beat sees cnt=1, then cnt=0
    send(2'd3, 8'h00, 1'b1, 8'h01, 1'b0);
    send(2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
    drain();

    // Backpressure: 5 mixed beats, output stalled
    bus.out_ready = 1'b0;
    fork
      begin
        send(2'd0, 8'h2D, 1'b0, 8'h3B, 1'b0);
        send(2'd1, 8'h80, 1'b0, 8'hFF, 1'b0);
        send(2'd2, 8'h59, 1'b0, 8'h7D, 1'b0);
        send(2'd3, 8'h00, 1'b0, 8'h01, 1'b0);
        send(2'd2, 8'h5A, 1'b0, 8'h70, 1'b1);
      end
      begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        check("bp_out_valid",    32'(bus.out_valid), 32'd1);
        held = {bus.out_mode, bus.out_err, bus.out_data};
        check("bp_held_first", 32'(held), 32'({2'd0, 1'b0, 8'h3B}));
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check("bp_stable", 32'({bus.out_valid, bus.out_mode, bus.out_err, bus.out_data}),
                32'({1'b1, held}));
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Random round trips through BIN2GRAY / GRAY2BIN
    for (int i = 0; i < 24; i++) begin
      rd = W'($urandom_range(0, 255));
      rm = 2'($urandom_range(0, 1));
      send(rm, rd, 1'b0, (rm == 2'd0) ? gray_of(rd) : bin_of(rd), 1'b0);
    end
    drain();

    // Reset mid-stream with both stages full (cnt is 2 before these beats)
    bus.out_ready = 1'b0;
    send(2'd3, 8'h00, 1'b0, 8'h03, 1'b0);
    send(2'd3, 8'h00, 1'b0, 8'h02, 1'b0);
    @(negedge clk);
    check("mid_full_in_ready", 32'(bus.in_ready), 32'd0);
    #3;
    rst = 1'b1;
    #1;
    check("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_out_data",  32'(bus.out_data),  32'd0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst           = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    send(2'd3, 8'h00, 1'b0, 8'h00, 1'b0);
    send(2'd3, 8'h00, 1'b0, 8'h01, 1'b0);
    drain();

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global time limit so the run always ends
  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "time limit");
  end

endmodule
